// File: rtl/sinh_key_nguoc.sv
// AES-128 inverse key schedule: walks round keys 10 down to 0,
// one key per accepted handshake, using an in-block forward S-box.
module sinh_key_nguoc #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [0:127] key_last,
  input  logic         key_ready,
  output logic [0:127] round_key,
  output logic [0:3]   round_idx,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, EMIT} state_t;

  // Byte b of the S-box sits at bits [2047-8b -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[~{b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  state_t         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [3:0]     idx_q, idx_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [31:0]    w0, w1, w2, w3;
  logic [31:0]    p0, p1, p2, p3;
  logic [31:0]    rot, g;
  logic [127:0]   inv_key;

  always_comb begin
    w0  = key_q[127:96];
    w1  = key_q[95:64];
    w2  = key_q[63:32];
    w3  = key_q[31:0];
    p3  = w3 ^ w2;
    p2  = w2 ^ w1;
    p1  = w1 ^ w0;
    rot = {p3[23:0], p3[31:24]};
    g   = {sbox(rot[31:24]), sbox(rot[23:16]),
           sbox(rot[15:8]),  sbox(rot[7:0])}
        ^ {rcon(idx_q), 24'h0};
    p0  = w0 ^ g;
    inv_key = {p0, p1, p2, p3};
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_last;
          idx_d   = 4'(NR);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (key_ready) begin
          if (idx_q != 4'd0) begin
            key_d = inv_key;
            idx_d = idx_q - 4'd1;
          end else begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign round_key = key_q;
  assign round_idx = idx_q;
  assign key_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/sinh_key_nguoc.md
Name: sinh_key_nguoc

Overview:
Iterative AES-128 inverse key schedule for the decryption datapath. It is loaded with the last round key (round 10) and walks the expansion backwards, emitting round keys 10, 9, …, 0 one per accepted handshake. This lets the inverse cipher derive keys on the fly instead of storing all eleven. It is the reverse-direction counterpart of the forward per-round subkey generator.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is supported, and the Rcon table covers indices 1..10.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state and outputs
start  input  1  load request; sampled only in IDLE
key_last  input  [0:127]  round-10 key; bit 0 is MSB, word w0 = [0:31]
key_ready  input  1  consumer accepts round_key this cycle
round_key  output  [0:127]  current round key, registered
round_idx  output  [0:3]  round number of round_key (10 down to 0)
key_valid  output  1  round_key/round_idx valid
busy  output  1  high from the cycle after start through the final handshake
done  output  1  one-cycle pulse after round 0 is accepted

Behaviour:
- Reset: round_key=0, round_idx=0, key_valid=0, busy=0, done=0, FSM=IDLE.
- States: IDLE, EMIT.
- IDLE, start=1 at edge T:
  - key_reg<=key_last, idx<=10, FSM<=EMIT.
  - At T+1: key_valid=1, busy=1, round_idx=10, round_key=key_last.
- IDLE, start=0: outputs hold 0 except done (see below). key_last is ignored.
- EMIT, key_ready=0: hold round_key, round_idx and key_valid unchanged. No stall limit.
- EMIT, key_ready=1 and idx>0:
  - key_reg<=inv_round(key_reg, Rcon[idx]), idx<=idx-1.
  - The new key is valid the next cycle, so throughput is 1 key/cycle with key_ready held high.
- EMIT, key_ready=1 and idx=0:
  - FSM<=IDLE; key_valid, busy<=0; done<=1 for exactly one cycle.
  - round_key and round_idx keep their last values.
- inv_round, with input words w0..w3 and outputs p0..p3:
  - p3=w3^w2; p2=w2^w1; p1=w1^w0.
  - p0=w0^G(p3,Rcon[idx]).
  - G(x,r) = SubWord(RotWord(x)) ^ {r,24'h0}; RotWord rotates bytes left by one byte.
  - SubWord applies the forward AES S-box to each of the 4 bytes. It is combinational and instantiated inside this block.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36. idx=0 never indexes the table.
- The full inverse round is combinational from key_reg and registered in the same cycle; there is no multicycle path.
- start while busy: ignored, with no restart and no error.
- start in the same cycle as done: accepted, because FSM is already IDLE on that edge; a new sequence begins, valid 1 cycle later.
- reset mid-sequence: the next cycle is in the reset state. No partial key is emitted afterwards.
- Total latency with key_ready always high: start at T gives keys at T+1..T+11 (round 10..0) and done at T+12.

Test Plan:
- FIPS-197 A.1: key_last = d014f9a8 c9ee2589 e13f0cc8 b6630ca6, key_ready=1.
  - -> idx 10 = same key at T+1; idx 9 = ac7766f3 19fadc21 28d12941 575c006e at T+2.
  - -> idx 0 = 2b7e1516 28aed2a6 abf71588 09cf4f3c at T+11; done pulse at T+12.
- Backpressure: same vector, key_ready toggled 1,0,0,1,…
  - -> round_key/round_idx stable while key_ready=0; the sequence of 11 keys is identical to the first test.
  - -> done appears the cycle after the 11th accepted handshake.
- Zero key: key_last = 0 -> the sequence matches a software inverse schedule; idx 9 must equal the forward round-9 key of the derived round-0 key (round-trip check with the forward generator).
- Busy start: pulse start at T+4 with a different key_last -> ignored; the output sequence is unchanged.
- Back-to-back: assert start on the done cycle -> key_valid re-asserts the next cycle with round_idx=10 and the new key.
- Reset at T+6 mid-sequence -> at T+7: key_valid=0, busy=0, round_key=0, round_idx=0; no done pulse.
